// File: rtl/htif_uart_if.sv
// rtl/htif_uart_if.sv - htif byte handshake bundle between htif (master) and the UART (slave)
interface htif_uart_if;
   logic       rx_ready;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_ready;
   logic       tx_valid;
   logic [7:0] tx_data;

   modport master (
      input  rx_valid, rx_data, tx_ready,
      output rx_ready, tx_valid, tx_data
   );

   modport slave (
      output rx_valid, rx_data, tx_ready,
      input  rx_ready, tx_valid, tx_data
   );
endinterface

// File: rtl/htif_uart.sv
// rtl/htif_uart.sv - htif serial front end, 8N1 default, 8E1 when HTIF_UART_PARITY_EN is defined
module htif_uart #(
   parameter int CLOCK_HZ     = 50000000,
   parameter int BAUD         = 115200,
   parameter int RX_FIFO_LOG2 = 3
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       serial_in,
   output logic       serial_out,
   htif_uart_if.slave htif,
   output logic       framing_error,
   output logic       overrun
);
   localparam int DIV   = CLOCK_HZ / BAUD;
   localparam int CW    = $clog2(DIV);
   localparam int DEPTH = 1 << RX_FIFO_LOG2;
   typedef logic [CW-1:0] cnt_t;
   localparam cnt_t CNT_FULL = cnt_t'(DIV - 1);
   localparam cnt_t CNT_HALF = cnt_t'(DIV / 2 - 1);
   localparam logic [RX_FIFO_LOG2:0] PTR_FULL_XOR = {1'b1, {RX_FIFO_LOG2{1'b0}}};

   typedef enum logic [2:0] {
      R_IDLE, R_START, R_DATA,
`ifdef HTIF_UART_PARITY_EN
      R_PARITY,
`endif
      R_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      T_IDLE, T_START, T_DATA,
`ifdef HTIF_UART_PARITY_EN
      T_PARITY,
`endif
      T_STOP
   } tx_state_t;

   // ---------------- receive path ----------------
   logic [1:0] sync_q, sync_d;
   rx_state_t  rx_state_q, rx_state_d;
   cnt_t       rx_cnt_q, rx_cnt_d;
   logic [2:0] rx_bit_q, rx_bit_d;
   logic [7:0] rx_shift_q, rx_shift_d;
   logic       fe_q, fe_d;
   logic       ov_q, ov_d;
   logic       rx_push_req;
`ifdef HTIF_UART_PARITY_EN
   logic       par_bad_q, par_bad_d;
`endif

   assign sync_d = {sync_q[0], serial_in};

   // RX frame FSM: mid-bit sampling of the synchronised line, stop-bit decides push vs error
   always_comb begin
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_shift_d  = rx_shift_q;
      rx_push_req = 1'b0;
      fe_d        = 1'b0;
`ifdef HTIF_UART_PARITY_EN
      par_bad_d   = par_bad_q;
`endif
      if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
      case (rx_state_q)
         R_IDLE: begin
            if (!sync_q[1]) begin
               rx_cnt_d   = CNT_HALF;
               rx_state_d = R_START;
            end
         end
         R_START: begin
            if (rx_cnt_q == '0) begin
               if (sync_q[1]) begin
                  rx_state_d = R_IDLE;
               end else begin
                  rx_state_d = R_DATA;
                  rx_cnt_d   = CNT_FULL;
                  rx_bit_d   = '0;
               end
            end
         end
         R_DATA: begin
            if (rx_cnt_q == '0) begin
               rx_shift_d[rx_bit_q] = sync_q[1];
               rx_cnt_d             = CNT_FULL;
               rx_bit_d             = rx_bit_q + 1'b1;
               if (rx_bit_q == 3'd7) begin
`ifdef HTIF_UART_PARITY_EN
                  rx_state_d = R_PARITY;
`else
                  rx_state_d = R_STOP;
`endif
               end
            end
         end
`ifdef HTIF_UART_PARITY_EN
         R_PARITY: begin
            if (rx_cnt_q == '0) begin
               par_bad_d  = sync_q[1] ^ (^rx_shift_q);
               rx_cnt_d   = CNT_FULL;
               rx_state_d = R_STOP;
            end
         end
`endif
         R_STOP: begin
            if (rx_cnt_q == '0) begin
               rx_state_d = R_IDLE;
`ifdef HTIF_UART_PARITY_EN
               if (sync_q[1] && !par_bad_q) rx_push_req = 1'b1;
`else
               if (sync_q[1]) rx_push_req = 1'b1;
`endif
               else fe_d = 1'b1;
            end
         end
         default: rx_state_d = R_IDLE;
      endcase
   end

   // RX synchroniser, FSM registers and error pulse flops
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= 2'b11;
         rx_state_q <= R_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         fe_q       <= 1'b0;
         ov_q       <= 1'b0;
`ifdef HTIF_UART_PARITY_EN
         par_bad_q  <= 1'b0;
`endif
      end else begin
         sync_q     <= sync_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         fe_q       <= fe_d;
         ov_q       <= ov_d;
`ifdef HTIF_UART_PARITY_EN
         par_bad_q  <= par_bad_d;
`endif
      end
   end

   // ---------------- RX FIFO ----------------
   logic [RX_FIFO_LOG2:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [7:0]            mem_q [DEPTH];
   logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_FULL_XOR);
   assign fifo_pop   = !fifo_empty && htif.rx_ready;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign fifo_push  = rx_push_req && (!fifo_full || fifo_pop);
   assign ov_d       = rx_push_req && fifo_full && !fifo_pop;

   // FIFO pointer advance
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (fifo_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // FIFO pointer registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // FIFO storage; contents are only visible while non-empty so no reset is needed
   always_ff @(posedge clock) begin
      if (fifo_push) mem_q[wr_ptr_q[RX_FIFO_LOG2-1:0]] <= rx_shift_q;
   end

   assign htif.rx_valid = !fifo_empty;
   assign htif.rx_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[RX_FIFO_LOG2-1:0]];
   assign framing_error = fe_q;
   assign overrun       = ov_q;

   // ---------------- transmit path ----------------
   tx_state_t  tx_state_q, tx_state_d;
   cnt_t       tx_cnt_q, tx_cnt_d;
   logic [2:0] tx_bit_q, tx_bit_d;
   logic [7:0] tx_shift_q, tx_shift_d;
   logic       so_q, so_d;
   logic       tx_ready_q, tx_ready_d;

   // TX frame FSM: each state holds the line for DIV clocks, line value registered
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      so_d       = so_q;
      tx_ready_d = tx_ready_q;
      if (tx_cnt_q != '0) tx_cnt_d = tx_cnt_q - 1'b1;
      case (tx_state_q)
         T_IDLE: begin
            if (htif.tx_valid && tx_ready_q) begin
               tx_shift_d = htif.tx_data;
               so_d       = 1'b0;
               tx_cnt_d   = CNT_FULL;
               tx_ready_d = 1'b0;
               tx_state_d = T_START;
            end
         end
         T_START: begin
            if (tx_cnt_q == '0) begin
               so_d       = tx_shift_q[0];
               tx_cnt_d   = CNT_FULL;
               tx_bit_d   = '0;
               tx_state_d = T_DATA;
            end
         end
         T_DATA: begin
            if (tx_cnt_q == '0) begin
               tx_cnt_d = CNT_FULL;
               if (tx_bit_q == 3'd7) begin
`ifdef HTIF_UART_PARITY_EN
                  so_d       = ^tx_shift_q;
                  tx_state_d = T_PARITY;
`else
                  so_d       = 1'b1;
                  tx_state_d = T_STOP;
`endif
               end else begin
                  tx_bit_d = tx_bit_q + 1'b1;
                  so_d     = tx_shift_q[tx_bit_d];
               end
            end
         end
`ifdef HTIF_UART_PARITY_EN
         T_PARITY: begin
            if (tx_cnt_q == '0) begin
               so_d       = 1'b1;
               tx_cnt_d   = CNT_FULL;
               tx_state_d = T_STOP;
            end
         end
`endif
         T_STOP: begin
            if (tx_cnt_q == '0) begin
               tx_ready_d = 1'b1;
               tx_state_d = T_IDLE;
            end
         end
         default: tx_state_d = T_IDLE;
      endcase
   end

   // TX registers; reset forces the line idle immediately
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= T_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         so_q       <= 1'b1;
         tx_ready_q <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         so_q       <= so_d;
         tx_ready_q <= tx_ready_d;
      end
   end

   assign serial_out    = so_q;
   assign htif.tx_ready = tx_ready_q;
endmodule

// File: tb/tb_htif_uart.sv
// tb/tb_htif_uart.sv - directed self-checking bench for htif_uart at DIV=16
`timescale 1ns/1ps
module tb_htif_uart;
   localparam int DIV = 16;
`ifdef HTIF_UART_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic clock    = 1'b0;
   logic reset_n  = 1'b0;
   logic drv_line = 1'b1;
   logic loopback = 1'b0;
   logic serial_in, serial_out, framing_error, overrun;
   int   checks   = 0;
   int   failures = 0;
   int   fe_cnt   = 0;
   int   ov_cnt   = 0;

   htif_uart_if u_if();

   assign serial_in = loopback ? serial_out : drv_line;

   htif_uart #(.CLOCK_HZ(160), .BAUD(10), .RX_FIFO_LOG2(3)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .serial_in     (serial_in),
      .serial_out    (serial_out),
      .htif          (u_if.slave),
      .framing_error (framing_error),
      .overrun       (overrun)
   );

   always #5 clock = ~clock;

   // pulse counters sampled away from the active edge
   always @(negedge clock) begin
      if (framing_error) fe_cnt++;
      if (overrun)       ov_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // drive one host frame; returns the cycle index (from the start bit) at which rx_valid was first seen
   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, output int first);
      logic [10:0] bits;
      int          n;
      n     = 0;
      first = -1;
      bits  = '1;
      bits[0]   = 1'b0;
      bits[8:1] = d;
      if (NBITS == 11) bits[9] = par;
      bits[NBITS-1] = stop;
      for (int i = 0; i < NBITS; i++) begin
         drv_line = bits[i];
         repeat (DIV) begin
            @(negedge clock);
            n++;
            if (u_if.rx_valid && first < 0) first = n;
         end
      end
      drv_line = 1'b1;
   endtask

   task automatic pop();
      u_if.rx_ready = 1'b1;
      @(negedge clock);
      u_if.rx_ready = 1'b0;
   endtask

   task automatic tx_check(input logic [7:0] d);
      logic [10:0] bits;
      int          errs;
      int          low;
      errs = 0;
      low  = 0;
      bits = '1;
      bits[0]   = 1'b0;
      bits[8:1] = d;
      if (NBITS == 11) bits[9] = ^d;
      u_if.tx_data  = d;
      u_if.tx_valid = 1'b1;
      @(negedge clock);
      u_if.tx_valid = 1'b0;
      u_if.tx_data  = ~d;
      for (int i = 0; i < NBITS; i++) begin
         check($sformatf("tx_%0h_bit%0d", d, i), {31'd0, serial_out}, {31'd0, bits[i]});
         for (int c = 0; c < DIV; c++) begin
            if (serial_out !== bits[i]) errs++;
            if (!u_if.tx_ready) low++;
            @(negedge clock);
         end
      end
      check("tx_hold_errs", errs, 0);
      check("tx_ready_low_clocks", low, NBITS * DIV);
      check("tx_ready_back", {31'd0, u_if.tx_ready}, 1);
   endtask

   task automatic wait_rx(input string tag, input int budget);
      int n;
      n = 0;
      while (!u_if.rx_valid && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(tag, {31'd0, u_if.rx_valid}, 1);
   endtask

   initial begin
      int first;
      int fe0;
      int ov0;
      u_if.rx_ready = 1'b0;
      u_if.tx_valid = 1'b0;
      u_if.tx_data  = 8'h00;
      repeat (3) @(negedge clock);
      check("rst_serial_out", {31'd0, serial_out}, 1);
      check("rst_rx_valid", {31'd0, u_if.rx_valid}, 0);
      check("rst_tx_ready", {31'd0, u_if.tx_ready}, 1);
      check("rst_framing_error", {31'd0, framing_error}, 0);
      check("rst_overrun", {31'd0, overrun}, 0);
      check("rst_rx_data", {24'd0, u_if.rx_data}, 0);
      reset_n = 1'b1;
      @(negedge clock);

      // single byte, latency: stop sample at cycle NBITS*DIV-5 from the start bit edge
      send_frame(8'hA5, 1'b0, 1'b1, first);
      check("rx_latency", first, NBITS * DIV - 5);
      check("rx_a5_valid", {31'd0, u_if.rx_valid}, 1);
      check("rx_a5_data", {24'd0, u_if.rx_data}, 32'hA5);
      pop();
      check("rx_a5_popped", {31'd0, u_if.rx_valid}, 0);

      tx_check(8'h3C);

      // fill past capacity with rx_ready low
      ov0 = ov_cnt;
      for (int i = 0; i < 9; i++) send_frame(8'(i), ^(8'(i)), 1'b1, first);
      check("overrun_pulses", ov_cnt - ov0, 1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("fifo_order_%0d", i), {24'd0, u_if.rx_data}, i);
         pop();
      end
      check("fifo_drained", {31'd0, u_if.rx_valid}, 0);

      // short glitch on the line
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      drv_line = 1'b0;
      repeat (5) @(negedge clock);
      drv_line = 1'b1;
      repeat (3 * DIV) @(negedge clock);
      check("glitch_no_push", {31'd0, u_if.rx_valid}, 0);
      check("glitch_no_fe", fe_cnt - fe0, 0);
      check("glitch_no_ov", ov_cnt - ov0, 0);

      // bad stop bit, then a good frame
      fe0 = fe_cnt;
      send_frame(8'h55, 1'b0, 1'b0, first);
      repeat (2 * DIV) @(negedge clock);
      check("stop_low_fe", fe_cnt - fe0, 1);
      check("stop_low_no_push", {31'd0, u_if.rx_valid}, 0);
      send_frame(8'h12, 1'b0, 1'b1, first);
      check("after_fe_valid", {31'd0, u_if.rx_valid}, 1);
      check("after_fe_data", {24'd0, u_if.rx_data}, 32'h12);
      pop();

`ifdef HTIF_UART_PARITY_EN
      fe0 = fe_cnt;
      send_frame(8'h03, 1'b1, 1'b1, first);
      check("parity_bad_fe", fe_cnt - fe0, 1);
      check("parity_bad_no_push", {31'd0, u_if.rx_valid}, 0);
      send_frame(8'h03, 1'b0, 1'b1, first);
      check("parity_ok_data", {24'd0, u_if.rx_data}, 32'h03);
      pop();
`endif
      tx_check(8'h01);

      // reset in the middle of a TX frame (bit 4) and an RX frame, with one byte queued
      send_frame(8'h99, 1'b0, 1'b1, first);
      u_if.tx_data  = 8'h00;
      u_if.tx_valid = 1'b1;
      @(negedge clock);
      u_if.tx_valid = 1'b0;
      drv_line = 1'b0;
      repeat (5 * DIV + 5) @(negedge clock);
      check("pre_reset_line_low", {31'd0, serial_out}, 0);
      check("pre_reset_queued", {31'd0, u_if.rx_valid}, 1);
      #2 reset_n = 1'b0;
      #1;
      check("async_rst_serial_out", {31'd0, serial_out}, 1);
      check("async_rst_tx_ready", {31'd0, u_if.tx_ready}, 1);
      check("async_rst_fifo_empty", {31'd0, u_if.rx_valid}, 0);
      drv_line = 1'b1;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);

      // loop TX back into RX
      fe0 = fe_cnt;
      loopback = 1'b1;
      u_if.tx_data  = 8'h7E;
      u_if.tx_valid = 1'b1;
      @(negedge clock);
      u_if.tx_valid = 1'b0;
      wait_rx("roundtrip_timeout", 400);
      check("roundtrip_data", {24'd0, u_if.rx_data}, 32'h7E);
      check("roundtrip_no_fe", fe_cnt - fe0, 0);
      pop();
      loopback = 1'b0;
      repeat (2 * DIV) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
